// File: rtl/nn_pkg.sv
// Shared definitions for the neuron layer: one-hot FSM encoding and width helpers.
package nn_pkg;

  localparam int STATE_W = 6;

  // One-hot encodings, one bit per state.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 6'b000001,
    S_LOAD = 6'b000010,
    S_MUL  = 6'b000100,
    S_ADD  = 6'b001000,
    S_EMIT = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  // Ceiling log2, never below 1 so that single-entry index ports keep a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  // Accumulator wide enough to hold N full-scale products without overflow.
  function automatic int acc_width(input int dw, input int ww, input int ni);
    return dw + ww + $clog2(ni);
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Registered multiplier feeding an accumulator. Signedness is fixed at elaboration.
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_mul_en,
  input  logic                i_add_en,
  input  logic [DATA_W-1:0]   i_x,
  input  logic [WEIGHT_W-1:0] i_w,
  output logic [ACC_W-1:0]    o_acc
);

  localparam int PW = DATA_W + WEIGHT_W;

  logic [PW-1:0]    w_xe;
  logic [PW-1:0]    w_we;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_mul_ext;
  logic [PW-1:0]    r_mul;
  logic [ACC_W-1:0] r_acc;

  // The low PW bits of the product of extended operands equal the exact
  // signed or unsigned product, so one multiplier serves both modes.
  if (SIGNED != 0) begin : g_signed
    assign w_xe      = {{WEIGHT_W{i_x[DATA_W-1]}}, i_x};
    assign w_we      = {{DATA_W{i_w[WEIGHT_W-1]}}, i_w};
    assign w_mul_ext = {{(ACC_W-PW){r_mul[PW-1]}}, r_mul};
  end else begin : g_unsigned
    assign w_xe      = {{WEIGHT_W{1'b0}}, i_x};
    assign w_we      = {{DATA_W{1'b0}}, i_w};
    assign w_mul_ext = {{(ACC_W-PW){1'b0}}, r_mul};
  end

  assign w_prod = w_xe * w_we;
  assign o_acc  = r_acc;

  // Product register and accumulator; clear wins over add.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul <= '0;
      r_acc <= '0;
    end else begin
      if (i_mul_en) r_mul <= w_prod;
      if (i_clr) r_acc <= '0;
      else if (i_add_en) r_acc <= r_acc + w_mul_ext;
    end
  end

endmodule

// File: rtl/nn_neuron_layer.sv
// Neuron layer: buffers one input vector from the byte stream, then evaluates
// N_NEURONS dot products in turn on a single shared multiply-accumulate unit.
//
// state | meaning
// IDLE  | waiting for the first sample of a vector
// LOAD  | collecting the remaining samples into the input buffer
// MUL   | register x[i]*w[n][i]
// ADD   | accumulate the product, advance input index
// EMIT  | present neuron n result, advance neuron index
// DONE  | pulse trigOut, return to IDLE
module nn_neuron_layer
  import nn_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 8,
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 4,
  parameter int SIGNED    = 0,
  parameter int RELU      = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          byteRecv,
  input  logic [DATA_W-1:0]                             byteIn,
  output logic                                          in_ready,
  input  logic                                          wr_en,
  input  logic [clog2(N_NEURONS*N_INPUTS)-1:0]          wr_addr,
  input  logic [WEIGHT_W-1:0]                           wr_data,
  output logic                                          wr_err,
  output logic [clog2(N_INPUTS):0]                      byteCnt,
  output logic                                          busy,
  output logic                                          out_valid,
  output logic [clog2(N_NEURONS)-1:0]                   out_idx,
  output logic [acc_width(DATA_W,WEIGHT_W,N_INPUTS)-1:0] dataOut,
  output logic                                          trigOut
);

  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, N_INPUTS);
  localparam int XW    = clog2(N_INPUTS);
  localparam int CW    = XW + 1;
  localparam int NW    = clog2(N_NEURONS);
  localparam int AW    = clog2(N_NEURONS * N_INPUTS);
  localparam int NWT   = N_NEURONS * N_INPUTS;

  localparam logic [XW-1:0] LAST_I   = XW'(N_INPUTS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_INPUTS - 1);
  localparam logic [NW-1:0] LAST_N   = NW'(N_NEURONS - 1);

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]   r_x [N_INPUTS];
  logic [WEIGHT_W-1:0] r_w [NWT];
  logic [CW-1:0]       r_cnt;
  logic [XW-1:0]       r_i;
  logic [NW-1:0]       r_n;
  logic [AW-1:0]       r_wptr;
  logic [ACC_W-1:0]    r_dout;
  logic [NW-1:0]       r_idx;
  logic                r_valid;
  logic                r_trig;
  logic                r_wr_err;

  logic                w_loading;
  logic                w_wr_ok;
  logic                w_clr;
  logic                w_mul_en;
  logic                w_add_en;
  logic [DATA_W-1:0]   w_xsel;
  logic [WEIGHT_W-1:0] w_wsel;
  logic [ACC_W-1:0]    w_acc;
  logic [ACC_W-1:0]    w_act;

  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_wr_ok   = wr_en && w_loading && (32'(wr_addr) < 32'(NWT));

  // Weights are walked linearly (neuron-major), so a running pointer replaces n*N_INPUTS+i.
  assign w_xsel = r_x[r_i];
  assign w_wsel = r_w[r_wptr];

  assign w_act = ((RELU != 0) && (SIGNED != 0) && w_acc[ACC_W-1]) ? '0 : w_acc;

  assign in_ready  = w_loading;
  assign busy      = !w_loading;
  assign byteCnt   = r_cnt;
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign dataOut   = r_dout;
  assign trigOut   = r_trig;
  assign wr_err    = r_wr_err;

  nn_mac_unit #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_mul_en(w_mul_en),
    .i_add_en(w_add_en),
    .i_x     (w_xsel),
    .i_w     (w_wsel),
    .o_acc   (w_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and MAC strobes; accumulator is held clear outside a neuron's computation.
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_mul_en = 1'b0;
    w_add_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (byteRecv) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_clr = 1'b1;
        if (byteRecv && (r_cnt == LAST_CNT)) w_next = S_MUL;
      end
      S_MUL: begin
        w_mul_en = 1'b1;
        w_next   = S_ADD;
      end
      S_ADD: begin
        w_add_en = 1'b1;
        w_next   = (r_i == LAST_I) ? S_EMIT : S_MUL;
      end
      S_EMIT: begin
        w_clr  = 1'b1;
        w_next = (r_n == LAST_N) ? S_DONE : S_MUL;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Input buffer, weight RAM, counters and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_i      <= '0;
      r_n      <= '0;
      r_wptr   <= '0;
      r_dout   <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_trig   <= 1'b0;
      r_wr_err <= 1'b0;
      for (int k = 0; k < N_INPUTS; k++) r_x[k] <= '0;
      for (int k = 0; k < NWT; k++) r_w[k] <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_trig   <= 1'b0;
      r_wr_err <= wr_en && !w_loading;
      if (w_wr_ok) r_w[wr_addr] <= wr_data;
      unique case (r_state)
        S_IDLE: begin
          if (byteRecv) begin
            r_x[0] <= byteIn;
            r_cnt  <= CW'(1);
          end
        end
        S_LOAD: begin
          if (byteRecv) begin
            r_x[r_cnt[XW-1:0]] <= byteIn;
            r_cnt  <= r_cnt + CW'(1);
            r_i    <= '0;
            r_n    <= '0;
            r_wptr <= '0;
          end
        end
        S_ADD: begin
          r_wptr <= r_wptr + AW'(1);
          if (r_i != LAST_I) r_i <= r_i + XW'(1);
        end
        S_EMIT: begin
          r_dout  <= w_act;
          r_idx   <= r_n;
          r_valid <= 1'b1;
          if (r_n != LAST_N) begin
            r_n <= r_n + NW'(1);
            r_i <= '0;
          end
        end
        S_DONE: begin
          r_trig <= 1'b1;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_neuron_layer.sv
// Bench for nn_neuron_layer: three instances (unsigned, signed+ReLU, signed) share one
// stimulus stream; expected results are queued per instance and popped by a monitor.
module tb_nn_neuron_layer;

  localparam int NI = 16;
  localparam int NN = 4;
  localparam int ND = 3;

  typedef struct {
    int          idx;
    logic [19:0] data;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       byteRecv;
  logic [7:0] byteIn;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  logic        in_ready_a  [ND];
  logic        wr_err_a    [ND];
  logic [4:0]  cnt_a       [ND];
  logic        busy_a      [ND];
  logic        out_valid_a [ND];
  logic [1:0]  idx_a       [ND];
  logic [19:0] dout_a      [ND];
  logic        trig_a      [ND];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_t q0[$], q1[$], q2[$];
  int   tq0[$], tq1[$], tq2[$];

  for (genvar k = 0; k < ND; k++) begin : g_dut
    nn_neuron_layer #(
      .DATA_W(8), .WEIGHT_W(8), .N_INPUTS(NI), .N_NEURONS(NN),
      .SIGNED((k > 0) ? 1 : 0), .RELU((k == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .byteRecv(byteRecv), .byteIn(byteIn),
      .in_ready(in_ready_a[k]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err_a[k]), .byteCnt(cnt_a[k]), .busy(busy_a[k]),
      .out_valid(out_valid_a[k]), .out_idx(idx_a[k]), .dataOut(dout_a[k]),
      .trigOut(trig_a[k])
    );
  end

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic exp_k(input int k, input int t, input int nres,
                       input logic [19:0] d0, input logic [19:0] d1,
                       input logic [19:0] d2, input logic [19:0] d3, input bit trig);
    logic [19:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int n = 0; n < nres; n++) begin
      exp_t e;
      e.idx  = n;
      e.data = d[n];
      e.cyc  = t + (2 * NI + 1) * (n + 1);
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    if (trig) begin
      case (k)
        0:       tq0.push_back(t + (2 * NI + 1) * NN + 1);
        1:       tq1.push_back(t + (2 * NI + 1) * NN + 1);
        default: tq2.push_back(t + (2 * NI + 1) * NN + 1);
      endcase
    end
  endtask

  task automatic chk_res(input int k);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out_valid dut%0d: got idx %0d data 0x%0h, required none (cycle %0d)",
               k, idx_a[k], dout_a[k], cyc);
    end else begin
      check("out_idx", k, 32'(idx_a[k]), 32'(e.idx));
      check("dataOut", k, 32'(dout_a[k]), 32'(e.data));
      check("result_cycle", k, cyc, e.cyc);
    end
  endtask

  task automatic chk_trig(input int k);
    int  c;
    bit  have;
    have = 1'b0;
    c = 0;
    case (k)
      0:       if (tq0.size() > 0) begin c = tq0.pop_front(); have = 1'b1; end
      1:       if (tq1.size() > 0) begin c = tq1.pop_front(); have = 1'b1; end
      default: if (tq2.size() > 0) begin c = tq2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_trigOut dut%0d: got pulse at cycle %0d, required none", k, cyc);
    end else begin
      check("trigOut_cycle", k, cyc, c);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a result or trigger.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (out_valid_a[k] === 1'b1) chk_res(k);
      if (trig_a[k] === 1'b1) chk_trig(k);
    end
  end

  task automatic write_range(input int lo, input int hi, input logic [7:0] val);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 6'(a);
      wr_data = val;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ramp=1 sends x[i]=i, otherwise every sample is v; t_last is the edge accepting the last sample.
  task automatic send_vec(input bit ramp, input logic [7:0] v, output int t_last);
    for (int i = 0; i < NI; i++) begin
      @(negedge clk);
      byteRecv = 1'b1;
      byteIn   = ramp ? 8'(i) : v;
    end
    t_last = cyc + 1;
    @(negedge clk);
    byteRecv = 1'b0;
  endtask

  task automatic wait_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      check({tag, "_dataOut"}, k, 32'(dout_a[k]), 32'd0);
      check({tag, "_out_idx"}, k, 32'(idx_a[k]), 32'd0);
      check({tag, "_out_valid"}, k, 32'(out_valid_a[k]), 32'd0);
      check({tag, "_trigOut"}, k, 32'(trig_a[k]), 32'd0);
      check({tag, "_wr_err"}, k, 32'(wr_err_a[k]), 32'd0);
      check({tag, "_byteCnt"}, k, 32'(cnt_a[k]), 32'd0);
      check({tag, "_busy"}, k, 32'(busy_a[k]), 32'd0);
      check({tag, "_in_ready"}, k, 32'(in_ready_a[k]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; byteRecv = 1'b0; byteIn = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // All weights 1, x=0..15 -> 120 per neuron; busy-time write and sample are rejected
    write_range(0, 63, 8'd1);
    send_vec(1'b1, 8'd0, t);
    for (int k = 0; k < ND; k++) exp_k(k, t, 4, 20'd120, 20'd120, 20'd120, 20'd120, 1'b1);
    wait_neg(t + 4);
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'd0;
    byteRecv = 1'b1; byteIn = 8'd99;
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      check("wr_err_pulse", k, 32'(wr_err_a[k]), 32'd1);
      check("byteCnt_busy", k, 32'(cnt_a[k]), 32'd16);
      check("busy_high", k, 32'(busy_a[k]), 32'd1);
      check("in_ready_busy", k, 32'(in_ready_a[k]), 32'd0);
    end
    @(negedge clk);
    wr_en = 1'b0; byteRecv = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      check("wr_err_end", k, 32'(wr_err_a[k]), 32'd0);
      check("byteCnt_after_drop", k, 32'(cnt_a[k]), 32'd16);
    end

    // Back-to-back: first sample of next vector accepted the edge after DONE; w[0] must still be 1
    wait_neg(t + 132);
    send_vec(1'b0, 8'd3, t);
    for (int k = 0; k < ND; k++) exp_k(k, t, 4, 20'd48, 20'd48, 20'd48, 20'd48, 1'b1);
    wait_neg(t + 140);

    // Full-scale operands: unsigned 16*255*255, signed 16*(-1)*(-1)
    write_range(0, 63, 8'd255);
    send_vec(1'b0, 8'd255, t);
    exp_k(0, t, 4, 20'd1040400, 20'd1040400, 20'd1040400, 20'd1040400, 1'b1);
    exp_k(1, t, 4, 20'd16, 20'd16, 20'd16, 20'd16, 1'b1);
    exp_k(2, t, 4, 20'd16, 20'd16, 20'd16, 20'd16, 1'b1);
    wait_neg(t + 140);

    // Neuron0 weights 0xFF, neuron1 weights 1, others 0; x all 2
    write_range(0, 15, 8'hFF);
    write_range(16, 31, 8'd1);
    write_range(32, 63, 8'd0);
    send_vec(1'b0, 8'd2, t);
    exp_k(0, t, 4, 20'd8160, 20'd32, 20'd0, 20'd0, 1'b1);
    exp_k(1, t, 4, 20'd0, 20'd32, 20'd0, 20'd0, 1'b1);
    exp_k(2, t, 4, 20'hFFFE0, 20'd32, 20'd0, 20'd0, 1'b1);
    wait_neg(t + 140);

    // Reset while neuron 2 is in ADD: only neurons 0 and 1 may report
    send_vec(1'b0, 8'd2, t);
    exp_k(0, t, 2, 20'd8160, 20'd32, 20'd0, 20'd0, 1'b0);
    exp_k(1, t, 2, 20'd0, 20'd32, 20'd0, 20'd0, 1'b0);
    exp_k(2, t, 2, 20'hFFFE0, 20'd32, 20'd0, 20'd0, 1'b0);
    wait_neg(t + 67);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    wait_neg(cyc + 150);

    // Reload weights after reset and run a fresh vector: 2*(0+..+15)
    write_range(0, 63, 8'd2);
    send_vec(1'b1, 8'd0, t);
    for (int k = 0; k < ND; k++) exp_k(k, t, 4, 20'd240, 20'd240, 20'd240, 20'd240, 1'b1);
    wait_neg(t + 140);

    check("results_outstanding", 0, q0.size(), 32'd0);
    check("results_outstanding", 1, q1.size(), 32'd0);
    check("results_outstanding", 2, q2.size(), 32'd0);
    check("trig_outstanding", 0, tq0.size(), 32'd0);
    check("trig_outstanding", 1, tq1.size(), 32'd0);
    check("trig_outstanding", 2, tq2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
